// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared opcode, ALU function and state definitions for the CPU control sequencer.
package cpu_ctrl_fsm_pkg;

  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_ALU   = 6'h01;
  localparam logic [5:0] OP_ALUI  = 6'h02;
  localparam logic [5:0] OP_LOAD  = 6'h03;
  localparam logic [5:0] OP_STORE = 6'h04;
  localparam logic [5:0] OP_JMP   = 6'h05;
  localparam logic [5:0] OP_JZ    = 6'h06;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [1:0] FN_ADD = 2'd0;
  localparam logic [1:0] FN_SUB = 2'd1;
  localparam logic [1:0] FN_AND = 2'd2;
  localparam logic [1:0] FN_OR  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

endpackage

// File: rtl/cpu_ctrl_fsm_mem_wait_timer.sv
// Wait-cycle counter for memory handshakes; expire flags the last permitted wait cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam int W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam int LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  logic [W-1:0] r_cnt;

  // Saturates at LAST so a disabled timer never wraps into a false expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (tick && (r_cnt != LAST[W-1:0])) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign expire = (MEM_TIMEOUT != 0) && (r_cnt == LAST[W-1:0]);

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle instruction sequencer: FETCH, DECODE, EXEC, optional MEM and WB, with
// illegal-opcode and memory-timeout flags and a retired-instruction counter.
module cpu_ctrl_fsm
  import cpu_ctrl_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       opcode_cpu,
  input  logic [1:0]       func_cpu,
  input  logic             zero_flag,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_rd,
  output logic             ir_load,
  output logic             en_de,
  output logic             alu_en,
  output logic             alu_imm,
  output logic [1:0]       alu_op,
  output logic             dmem_rd,
  output logic             dmem_wr,
  output logic             reg_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             busy,
  output logic             halted,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t           r_state;
  state_t           w_state_next;
  logic [5:0]       r_op;
  logic [1:0]       r_func;
  logic             r_err_illegal;
  logic             r_err_timeout;
  logic [CNT_W-1:0] r_instr_cnt;

  logic w_retire;
  logic w_set_illegal;
  logic w_set_timeout;
  logic w_timer_clear;
  logic w_timer_tick;
  logic w_timer_expire;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_timer_clear),
    .tick   (w_timer_tick),
    .expire (w_timer_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_op          <= '0;
      r_func        <= '0;
      r_err_illegal <= 1'b0;
      r_err_timeout <= 1'b0;
      r_instr_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_DECODE) begin
        r_op   <= opcode_cpu;
        r_func <= func_cpu;
      end
      if (w_set_illegal) r_err_illegal <= 1'b1;
      if (w_set_timeout) r_err_timeout <= 1'b1;
      if (w_retire)      r_instr_cnt   <= r_instr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_next  = r_state;
    imem_rd       = 1'b0;
    ir_load       = 1'b0;
    en_de         = 1'b0;
    alu_en        = 1'b0;
    alu_imm       = 1'b0;
    dmem_rd       = 1'b0;
    dmem_wr       = 1'b0;
    reg_we        = 1'b0;
    pc_inc        = 1'b0;
    pc_load       = 1'b0;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    w_set_timeout = 1'b0;
    w_timer_tick  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        imem_rd = 1'b1;
        // A ready arriving in the final allowed wait cycle still wins over the timeout.
        if (imem_ready) begin
          ir_load      = 1'b1;
          w_state_next = S_DECODE;
        end else begin
          w_timer_tick = 1'b1;
          if (w_timer_expire) begin
            w_set_timeout = 1'b1;
            w_state_next  = S_HALT;
          end
        end
      end
      S_DECODE: begin
        en_de        = 1'b1;
        w_state_next = S_EXEC;
      end
      S_EXEC: begin
        w_state_next = S_FETCH;
        w_retire     = 1'b1;
        case (r_op)
          OP_NOP:   pc_inc = 1'b1;
          OP_ALU: begin
            alu_en       = 1'b1;
            w_state_next = S_WB;
            w_retire     = 1'b0;
          end
          OP_ALUI: begin
            alu_en       = 1'b1;
            alu_imm      = 1'b1;
            w_state_next = S_WB;
            w_retire     = 1'b0;
          end
          OP_LOAD, OP_STORE: begin
            w_state_next = S_MEM;
            w_retire     = 1'b0;
          end
          OP_JMP:   pc_load = 1'b1;
          OP_JZ: begin
            pc_load = zero_flag;
            pc_inc  = ~zero_flag;
          end
          OP_HALT:  w_state_next = S_HALT;
          default: begin
            w_set_illegal = 1'b1;
            pc_inc        = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        dmem_rd = (r_op == OP_LOAD);
        dmem_wr = (r_op != OP_LOAD);
        if (dmem_ready) begin
          if (r_op == OP_LOAD) begin
            w_state_next = S_WB;
          end else begin
            pc_inc       = 1'b1;
            w_retire     = 1'b1;
            w_state_next = S_FETCH;
          end
        end else begin
          w_timer_tick = 1'b1;
          if (w_timer_expire) begin
            w_set_timeout = 1'b1;
            w_state_next  = S_HALT;
          end
        end
      end
      S_WB: begin
        reg_we       = 1'b1;
        pc_inc       = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_HALT: w_state_next = S_HALT;
      default: w_state_next = S_IDLE;
    endcase

    w_timer_clear = ((w_state_next == S_FETCH) || (w_state_next == S_MEM)) &&
                    (w_state_next != r_state);
  end

  assign alu_op      = ((r_state == S_EXEC) || (r_state == S_WB)) ? r_func : 2'b00;
  assign busy        = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted      = (r_state == S_HALT);
  assign err_illegal = r_err_illegal;
  assign err_timeout = r_err_timeout;
  assign instr_cnt   = r_instr_cnt;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: per-cycle strobe vectors with hand-computed expectations.
module tb_cpu_ctrl_fsm;
  import cpu_ctrl_fsm_pkg::*;

  localparam int CNT_W = 4;

  localparam logic [11:0] IMRD   = 12'h800;
  localparam logic [11:0] IRLD   = 12'h400;
  localparam logic [11:0] ENDE   = 12'h200;
  localparam logic [11:0] ALUEN  = 12'h100;
  localparam logic [11:0] ALUIMM = 12'h080;
  localparam logic [11:0] DMRD   = 12'h040;
  localparam logic [11:0] DMWR   = 12'h020;
  localparam logic [11:0] REGWE  = 12'h010;
  localparam logic [11:0] PCINC  = 12'h008;
  localparam logic [11:0] PCLD   = 12'h004;
  localparam logic [11:0] BUSY   = 12'h002;
  localparam logic [11:0] HALTD  = 12'h001;
  localparam logic [11:0] NONE   = 12'h000;
  localparam logic [5:0]  OP_X   = 6'h15;

  logic clk, rst_n, start, zero_flag, imem_ready, dmem_ready;
  logic [5:0] opcode_cpu;
  logic [1:0] func_cpu;
  logic imem_rd, ir_load, en_de, alu_en, alu_imm, dmem_rd, dmem_wr;
  logic reg_we, pc_inc, pc_load, busy, halted, err_illegal, err_timeout;
  logic [1:0] alu_op;
  logic [CNT_W-1:0] instr_cnt;
  logic [11:0] w_strobes;

  int n_checks = 0;
  int n_errors = 0;

  cpu_ctrl_fsm #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode_cpu(opcode_cpu), .func_cpu(func_cpu),
    .zero_flag(zero_flag), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_rd(imem_rd), .ir_load(ir_load), .en_de(en_de), .alu_en(alu_en), .alu_imm(alu_imm),
    .alu_op(alu_op), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .reg_we(reg_we), .pc_inc(pc_inc),
    .pc_load(pc_load), .busy(busy), .halted(halted), .err_illegal(err_illegal),
    .err_timeout(err_timeout), .instr_cnt(instr_cnt)
  );

  assign w_strobes = {imem_rd, ir_load, en_de, alu_en, alu_imm, dmem_rd, dmem_wr,
                      reg_we, pc_inc, pc_load, busy, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs in the low phase, then compare the strobe vector.
  task automatic cyc(input string tag, input logic im, input logic dm, input logic zf,
                     input logic [5:0] op, input logic [1:0] fn, input logic [11:0] exp);
    @(negedge clk);
    start = 1'b0; imem_ready = im; dmem_ready = dm; zero_flag = zf;
    opcode_cpu = op; func_cpu = fn;
    #1;
    check(tag, {20'd0, w_strobes}, {20'd0, exp});
  endtask

  task automatic do_start(input string tag, input logic [11:0] exp);
    @(negedge clk);
    start = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; opcode_cpu = OP_X;
    #1;
    check(tag, {20'd0, w_strobes}, {20'd0, exp});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; zero_flag = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    opcode_cpu = '0; func_cpu = '0;
    #12;
    check("rst_strobes", {20'd0, w_strobes}, 32'd0);
    check("rst_cnt", {28'd0, instr_cnt}, 32'd0);
    check("rst_errs", {30'd0, err_illegal, err_timeout}, 32'd0);
    check("rst_aluop", {30'd0, alu_op}, 32'd0);
    rst_n = 1'b1;

    // Test 1: ALU op, func 2
    do_start("t1_idle", NONE);
    cyc("t1_fetch", 1, 0, 0, OP_X, 2'd0, IMRD | IRLD | BUSY);
    cyc("t1_dec", 1, 0, 0, OP_ALU, 2'd2, ENDE | BUSY);
    cyc("t1_exec", 1, 0, 0, OP_X, 2'd1, ALUEN | BUSY);
    check("t1_aluop_exec", {30'd0, alu_op}, 32'd2);
    cyc("t1_wb", 1, 0, 0, OP_X, 2'd1, REGWE | PCINC | BUSY);
    check("t1_aluop_wb", {30'd0, alu_op}, 32'd2);
    $display("txn ALU done");

    // Test 2: LOAD with three dmem wait cycles
    cyc("t2_fetch", 1, 0, 0, OP_X, 2'd0, IMRD | IRLD | BUSY);
    check("t1_cnt", {28'd0, instr_cnt}, 32'd1);
    cyc("t2_dec", 1, 0, 0, OP_LOAD, 2'd0, ENDE | BUSY);
    cyc("t2_exec", 1, 0, 0, OP_X, 2'd0, BUSY);
    cyc("t2_mem0", 1, 0, 0, OP_X, 2'd0, DMRD | BUSY);
    cyc("t2_mem1", 1, 0, 0, OP_X, 2'd0, DMRD | BUSY);
    cyc("t2_mem2", 1, 0, 0, OP_X, 2'd0, DMRD | BUSY);
    cyc("t2_mem3", 1, 1, 0, OP_X, 2'd0, DMRD | BUSY);
    cyc("t2_wb", 1, 0, 0, OP_X, 2'd0, REGWE | PCINC | BUSY);
    $display("txn LOAD done");

    // Test 3: JZ taken then not taken
    cyc("t3a_fetch", 1, 0, 0, OP_X, 2'd0, IMRD | IRLD | BUSY);
    check("t2_cnt", {28'd0, instr_cnt}, 32'd2);
    cyc("t3a_dec", 1, 0, 0, OP_JZ, 2'd0, ENDE | BUSY);
    cyc("t3a_exec", 1, 0, 1, OP_X, 2'd0, PCLD | BUSY);
    cyc("t3b_fetch", 1, 0, 1, OP_X, 2'd0, IMRD | IRLD | BUSY);
    cyc("t3b_dec", 1, 0, 1, OP_JZ, 2'd0, ENDE | BUSY);
    cyc("t3b_exec", 1, 0, 0, OP_X, 2'd0, PCINC | BUSY);
    $display("txn JZ x2 done");

    // Test 4: illegal opcode, then a normal NOP
    cyc("t4_fetch", 1, 0, 0, OP_X, 2'd0, IMRD | IRLD | BUSY);
    check("t3_cnt", {28'd0, instr_cnt}, 32'd4);
    check("t4_ill_before", {31'd0, err_illegal}, 32'd0);
    cyc("t4_dec", 1, 0, 0, 6'h20, 2'd0, ENDE | BUSY);
    cyc("t4_exec", 1, 0, 0, OP_NOP, 2'd0, PCINC | BUSY);
    cyc("t4n_fetch", 1, 0, 0, OP_X, 2'd0, IMRD | IRLD | BUSY);
    check("t4_ill_set", {31'd0, err_illegal}, 32'd1);
    check("t4_cnt", {28'd0, instr_cnt}, 32'd5);
    cyc("t4n_dec", 1, 0, 0, OP_NOP, 2'd0, ENDE | BUSY);
    cyc("t4n_exec", 1, 0, 0, OP_X, 2'd0, PCINC | BUSY);
    $display("txn ILLEGAL+NOP done");

    // STORE, ALUI, JMP
    cyc("st_fetch", 1, 0, 0, OP_X, 2'd0, IMRD | IRLD | BUSY);
    check("t4_ill_sticky", {31'd0, err_illegal}, 32'd1);
    check("t4n_cnt", {28'd0, instr_cnt}, 32'd6);
    cyc("st_dec", 1, 0, 0, OP_STORE, 2'd0, ENDE | BUSY);
    cyc("st_exec", 1, 0, 0, OP_X, 2'd0, BUSY);
    cyc("st_mem", 1, 1, 0, OP_X, 2'd0, DMWR | PCINC | BUSY);
    cyc("ai_fetch", 1, 0, 0, OP_X, 2'd0, IMRD | IRLD | BUSY);
    cyc("ai_dec", 1, 0, 0, OP_ALUI, 2'd3, ENDE | BUSY);
    cyc("ai_exec", 1, 0, 0, OP_X, 2'd0, ALUEN | ALUIMM | BUSY);
    check("ai_aluop", {30'd0, alu_op}, 32'd3);
    cyc("ai_wb", 1, 0, 0, OP_X, 2'd0, REGWE | PCINC | BUSY);
    cyc("jmp_fetch", 1, 0, 0, OP_X, 2'd0, IMRD | IRLD | BUSY);
    check("ai_cnt", {28'd0, instr_cnt}, 32'd8);
    cyc("jmp_dec", 1, 0, 1, OP_JMP, 2'd0, ENDE | BUSY);
    cyc("jmp_exec", 1, 0, 0, OP_X, 2'd0, PCLD | BUSY);
    $display("txn STORE/ALUI/JMP done");

    // Ready arriving in the 4th wait cycle beats the timeout
    cyc("bnd_w0", 0, 0, 0, OP_X, 2'd0, IMRD | BUSY);
    cyc("bnd_w1", 0, 0, 0, OP_X, 2'd0, IMRD | BUSY);
    cyc("bnd_w2", 0, 0, 0, OP_X, 2'd0, IMRD | BUSY);
    cyc("bnd_w3", 1, 0, 0, OP_X, 2'd0, IMRD | IRLD | BUSY);
    cyc("bnd_dec", 1, 0, 0, OP_NOP, 2'd0, ENDE | BUSY);
    cyc("bnd_exec", 1, 0, 0, OP_X, 2'd0, PCINC | BUSY);
    $display("txn late-ready NOP done");

    // Test 5: imem_ready held low for 4 FETCH cycles -> timeout halt
    cyc("t5_w0", 0, 0, 0, OP_X, 2'd0, IMRD | BUSY);
    check("t5_to_before", {31'd0, err_timeout}, 32'd0);
    cyc("t5_w1", 0, 0, 0, OP_X, 2'd0, IMRD | BUSY);
    cyc("t5_w2", 0, 0, 0, OP_X, 2'd0, IMRD | BUSY);
    cyc("t5_w3", 0, 0, 0, OP_X, 2'd0, IMRD | BUSY);
    cyc("t5_halt", 0, 0, 0, OP_X, 2'd0, HALTD);
    check("t5_timeout", {31'd0, err_timeout}, 32'd1);
    check("t5_cnt", {28'd0, instr_cnt}, 32'd10);
    do_start("t5_start_ign", HALTD);
    cyc("t5_still_halt", 1, 0, 0, OP_X, 2'd0, HALTD);
    $display("txn timeout halt done");

    // Test 6: reset mid-WB, then clean restart
    pulse_reset();
    #1;
    check("t6_rst_errs", {30'd0, err_illegal, err_timeout}, 32'd0);
    do_start("t6_idle", NONE);
    cyc("t6_fetch", 1, 0, 0, OP_X, 2'd0, IMRD | IRLD | BUSY);
    cyc("t6_dec", 1, 0, 0, OP_ALU, 2'd1, ENDE | BUSY);
    cyc("t6_exec", 1, 0, 0, OP_X, 2'd0, ALUEN | BUSY);
    cyc("t6_wb", 1, 0, 0, OP_X, 2'd0, REGWE | PCINC | BUSY);
    #1; rst_n = 1'b0; #1;
    check("t6_async_strobes", {20'd0, w_strobes}, 32'd0);
    check("t6_async_aluop", {30'd0, alu_op}, 32'd0);
    check("t6_async_cnt", {28'd0, instr_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start("t6_restart", NONE);
    $display("txn reset mid-WB done");

    // 16 NOPs wrap the 4-bit counter to 0, then HALT opcode counts
    for (int i = 0; i < 16; i++) begin
      cyc("wr_fetch", 1, 0, 0, OP_X, 2'd0, IMRD | IRLD | BUSY);
      cyc("wr_dec", 1, 0, 0, OP_NOP, 2'd0, ENDE | BUSY);
      cyc("wr_exec", 1, 0, 0, OP_X, 2'd0, PCINC | BUSY);
    end
    cyc("h_fetch", 1, 0, 0, OP_X, 2'd0, IMRD | IRLD | BUSY);
    check("wrap_cnt", {28'd0, instr_cnt}, 32'd0);
    cyc("h_dec", 1, 0, 0, OP_HALT, 2'd0, ENDE | BUSY);
    cyc("h_exec", 1, 0, 0, OP_X, 2'd0, BUSY);
    cyc("h_halt", 1, 0, 0, OP_X, 2'd0, HALTD);
    check("h_cnt", {28'd0, instr_cnt}, 32'd1);
    check("h_errs", {30'd0, err_illegal, err_timeout}, 32'd0);
    $display("txn wrap+HALT done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
